// File: rtl/ser_tx.sv
// Serial transmitter: a start bit (0), then DATA_W payload bits LSB first, then a stop bit (1).
// Each bit lasts CLKS_PER_BIT clocks, and q is driven from a register.
module ser_tx #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic              q,
   output logic              busy,
   output logic              frame_done
);

   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam int IW = $clog2(DATA_W + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

   if (DATA_W < 1 || DATA_W > 32) begin : g_bad_data_w
      $error("ser_tx: DATA_W=%0d outside legal range 1..32", DATA_W);
   end
   if (CLKS_PER_BIT < 1 || CLKS_PER_BIT > 1024) begin : g_bad_clks_per_bit
      $error("ser_tx: CLKS_PER_BIT=%0d outside legal range 1..1024", CLKS_PER_BIT);
   end

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              q_q, q_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         q_q     <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         q_q     <= q_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      unique case (state_q)
         IDLE: begin
            if (din_valid) begin
               state_d = START;
               cnt_d   = '0;
               idx_d   = '0;
               shift_d = din;
            end
         end
         START: begin
            if (cnt_q == CNT_LAST) begin
               state_d = DATA;
               cnt_d   = '0;
               idx_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               shift_d = shift_q >> 1;
               if (idx_q == IDX_LAST) begin
                  state_d = STOP;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         STOP: begin
            if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // q_d is decoded from the next state so the registered q lines up with the state it belongs to.
   always_comb begin
      din_ready  = (state_q == IDLE);
      busy       = (state_q != IDLE);
      frame_done = (state_q == STOP) && (cnt_q == CNT_LAST);
      unique case (state_d)
         START:   q_d = 1'b0;
         DATA:    q_d = shift_d[0];
         default: q_d = 1'b1;
      endcase
   end

   assign q = q_q;

endmodule

// File: doc/ser_tx.md
SER_TX -- requirements
Module: ser_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 8: payload width in bits; legal range 1..32.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 4: clock cycles per serial bit; legal range 1..1024.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port din, input, DATA_W bits: parallel payload to transmit.
REQ-006 SHALL have port din_valid, input, 1 bit: the producer is offering din.
REQ-007 SHALL have port din_ready, output, 1 bit: the block can accept a word this cycle.
REQ-008 SHALL have port q, output, 1 bit: serial line; idles high.
REQ-009 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-010 SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of each frame.

Function
REQ-011 SHALL implement the FSM states IDLE, START, DATA and STOP.
REQ-012 SHALL drive din_ready high exactly when the state is IDLE; din_ready is a registered-state decode with no combinational path from din_valid.
REQ-013 SHALL accept a word on a rising edge where din_valid=1 and din_ready=1; on that edge it SHALL load din into the shift register, clear the bit-period counter and enter START.
REQ-014 SHALL ignore din and din_valid in every cycle where din_ready=0; changes to din after acceptance SHALL NOT affect the frame in progress.
REQ-015 In START, q SHALL be 0 for exactly CLKS_PER_BIT cycles, after which the state SHALL change to DATA.
REQ-016 In DATA, q SHALL present din[0] first and din[DATA_W-1] last (LSB first); each bit SHALL be held for exactly CLKS_PER_BIT cycles.
REQ-017 After the last data bit, the state SHALL change to STOP; q SHALL be 1 for exactly CLKS_PER_BIT cycles.
REQ-018 SHALL assert frame_done for exactly one cycle, during the final STOP cycle; the state SHALL then change to IDLE.
REQ-019 SHALL drive q registered, with no combinational glitch path, and drive q=1 in IDLE.
REQ-020 SHALL assert busy in START, DATA and STOP, and deassert it in IDLE.
REQ-021 SHALL make each frame span exactly (DATA_W+2)*CLKS_PER_BIT cycles, counted from the cycle after acceptance.
REQ-022 SHALL allow a new word to be accepted in the first IDLE cycle after a frame; the minimum accept-to-accept spacing SHALL be (DATA_W+2)*CLKS_PER_BIT+1 cycles.
REQ-023 With CLKS_PER_BIT=1, every bit SHALL last exactly one cycle, with no skipped or repeated bits.
REQ-024 The bit-period counter SHALL be $clog2(CLKS_PER_BIT+1) bits wide and the data-bit index $clog2(DATA_W+1) bits wide; neither SHALL wrap within a frame.
REQ-025 SHALL ignore din_valid held high continuously outside IDLE, then accept the held word on the next IDLE cycle.
REQ-026 SHALL flag illegal parameter values with an elaboration-time error or simulation-start error.

Reset
REQ-027 While rst=1, the block SHALL hold: state=IDLE, q=1, din_ready=1, busy=0, frame_done=0, counters=0 and shift register=0, taking effect immediately without waiting for clk.
REQ-028 rst asserted mid-frame SHALL abort the frame and discard the payload, with q returning to 1 in the same cycle.
REQ-029 After rst deasserts, the first word SHALL be acceptable on the first rising edge of clk.

Verification
REQ-030 Reset then idle: rst=1 for 2 cycles, then 0 with din_valid=0 -> q=1, din_ready=1, busy=0 and frame_done=0 throughout.
REQ-031 Single frame (DATA_W=8, CLKS_PER_BIT=4): accept din=8'hA5 -> q sequence per 4-cycle slot is 0,1,0,1,0,0,1,0,1,1; frame_done pulses at cycle 40 after acceptance; din_ready returns at cycle 41.
REQ-032 Back-to-back: din_valid held high with 8'h00 then 8'hFF -> second accept occurs exactly 41 cycles after the first; payload 8'hFF gives q low for 4 cycles, then high for 36 cycles.
REQ-033 din changed mid-frame: accept 8'h3C, then change din to 8'hC3 in DATA -> serialized bits still match 8'h3C.
REQ-034 Reset mid-frame: assert rst during data bit 3 of 8'h00 -> q=1 before the next clk edge, busy=0, din_ready=1; a new word is accepted on the first edge after release.
REQ-035 CLKS_PER_BIT=1, DATA_W=1: accept din=1 -> q sequence is 0,1,1 over 3 cycles, frame_done is high in cycle 3, and the next accept is possible in cycle 4.
